descram_chk: RTL and testbench
==============================

# descram_chk

Parametrised self-synchronising descrambler with a built-in PRBS checker, for the receive datapath directly after word alignment. Mode 0 descrambles the payload. Mode 1 treats the input as a pure PRBS stream, outputs the per-bit error pattern, and runs a lock state machine and a saturating bit-error counter for link bring-up and BER test.

## Interface

Parameters:
- DW, 32: word width, >= 1.
- PP, 7: polynomial degree, >= 2.
- POLY, 8'hC1: polynomial, PP+1 bits. Bit k = tap at x^k. POLY[0] and POLY[PP] must be 1.
- DI, 7'h7F: history register reset value, PP bits.
- LOCK_N, 4: consecutive clean words needed to declare lock, >= 1.
- UNLOCK_N, 4: consecutive errored words needed to drop lock, >= 1.
- ECW, 16: error counter width.

Ports:
- Ck  in  1  clock.
- Rs_n  in  1  reset, asynchronous, active-low.
- CE  in  1  clock enable, active high. When low, all state holds.
- Mode  in  1  0 = descramble, 1 = PRBS check. Quasi-static.
- Vld_i  in  1  input word valid.
- Dat_i  in  DW  received word. Dat_i[DW-1] is the oldest bit.
- Clr_Err  in  1  synchronous clear of Err_Cnt.
- Vld_o  out  1  output word valid.
- Dat_o  out  DW  descrambled word (Mode 0) or error pattern (Mode 1).
- Lock  out  1  PRBS lock indication.
- Err_Cnt  out  ECW  accumulated bit errors while locked.

## Operation

- A word is accepted on a rising Ck edge when CE=1 and Vld_i=1.
- History register H (PP bits) holds the last PP received bits. H[0] is the most recent.
- Each bit is computed from the stream r formed by H followed by Dat_i, oldest first:
  - out[j] = r[j] XOR (XOR over k=1..PP with POLY[k]=1 of the bit received k positions before r[j]).
- After an accepted word, H takes the newest PP bits of {H, Dat_i}. If DW >= PP, H takes Dat_i[PP-1:0].
- The computation is the same in both modes.
- Word classification, Mode 1 only: clean if out == 0, errored otherwise.

Lock FSM, states HUNT and LOCKED, with run counter RC:
- HUNT: a clean word increments RC; an errored word sets RC=0. When RC reaches LOCK_N, go to LOCKED and set RC=0.
- LOCKED: an errored word increments RC; a clean word sets RC=0. When RC reaches UNLOCK_N, go to HUNT and set RC=0.
- Mode=0: FSM is forced to HUNT with RC=0.
- Any change of Mode between accepted words: FSM goes to HUNT with RC=0. Err_Cnt is unaffected.
- Lock = (state == LOCKED), registered.

Err_Cnt:
- On an accepted word with Mode=1 and FSM already in LOCKED before that word, add popcount(out).
- Saturates at 2^ECW-1 and never wraps.
- Clr_Err=1 with CE=1 sets it to 0. Clear wins over a same-cycle increment.

Reset, while Rs_n=0 (asynchronous):
- H = DI.
- Dat_o = 0, Vld_o = 0, Lock = 0, Err_Cnt = 0.
- FSM in HUNT, RC = 0.
- Reset mid-stream discards all state. The first word after release uses DI as history.

## Timing

- Latency is one cycle. The word accepted at edge t appears on Dat_o with Vld_o=1 after edge t.
- CE=1 with Vld_i=0: Vld_o=0 after the edge; Dat_o, H, FSM and Err_Cnt hold.
- CE=0: all registers hold, including Vld_o.
- Lock and Err_Cnt update on the same edge as the Dat_o of the word that changed them.
- Lock rises with the LOCK_N-th consecutive clean word and falls with the UNLOCK_N-th consecutive errored word.
- No combinational path from inputs to outputs.

## Test plan

All tests use default parameters.

1. Reset: hold Rs_n=0 while driving random Dat_i and Vld_i.
   -> Dat_o=0, Vld_o=0, Lock=0, Err_Cnt=0. Releasing Rs_n changes nothing until the first accepted word.
2. Mode 0: feed 8 words of 32'hDEADBEEF scrambled by a model self-sync scrambler seeded 7'h7F, Vld_i toggling 1/0.
   -> Every Vld_o pulse carries 32'hDEADBEEF, one cycle after its Vld_i. Lock stays 0.
3. Mode 1: feed a continuous PRBS7 stream in phase with history DI.
   -> Lock=1 on the 4th output word. Err_Cnt stays 0 over 100 words.
4. Mode 1, locked: flip one mid-word bit (bit 15) in one word.
   -> Error multiplication gives 3 error bits (at the flip, +6 and +7 positions).
   -> Err_Cnt=3 once those positions have been processed. Lock stays 1.
5. Mode 1, locked: feed 4 consecutive words of 32'hFFFFFFFF.
   -> Lock falls with the 4th output. Err_Cnt then freezes.
   -> Restoring PRBS relocks after 4 clean words.
6. ECW=4 instance: inject errors until saturation.
   -> Err_Cnt holds at 15.
   -> Clr_Err in the same cycle as an errored word gives Err_Cnt=0. Pulse Rs_n low mid-stream: all outputs 0 immediately.

Source files
------------

// File: rtl/descram_chk.sv
// rtl/descram_chk.sv - self-synchronising descrambler with PRBS lock checker
// and a saturating bit-error counter.
module descram_chk #(
    parameter int              DW       = 32,
    parameter int              PP       = 7,
    parameter logic [PP:0]     POLY     = 8'hC1,
    parameter logic [PP-1:0]   DI       = 7'h7F,
    parameter int              LOCK_N   = 4,
    parameter int              UNLOCK_N = 4,
    parameter int              ECW      = 16
) (
    input  logic           Ck,
    input  logic           Rs_n,
    input  logic           CE,
    input  logic           Mode,
    input  logic           Vld_i,
    input  logic [DW-1:0]  Dat_i,
    input  logic           Clr_Err,
    output logic           Vld_o,
    output logic [DW-1:0]  Dat_o,
    output logic           Lock,
    output logic [ECW-1:0] Err_Cnt
);

    localparam int RCMAX = (LOCK_N > UNLOCK_N) ? LOCK_N : UNLOCK_N;
    localparam int RCW   = $clog2(RCMAX + 1);
    localparam int PCW   = $clog2(DW + 1);
    localparam int SW    = ((ECW > PCW) ? ECW : PCW) + 1;
    localparam logic [SW-1:0] SAT = {{(SW - ECW){1'b0}}, {ECW{1'b1}}};

    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [PP-1:0]    hist;
    logic [0:0]       state;
    logic [RCW-1:0]   rc;
    logic [PP+DW-1:0] strm;
    logic [DW-1:0]    descr;
    logic [PCW-1:0]   pop;
    logic [SW-1:0]    sum;
    logic [RCW-1:0]   rc_inc;
    logic             accept;
    logic             clean;

    assign accept = CE & Vld_i;
    assign clean  = (descr == '0);
    assign rc_inc = rc + 1'b1;
    assign Lock   = (state == LOCKED);

    // Stream index 0 is the newest bit, so "k positions earlier" is index j+k.
    always_comb begin
        strm  = {hist, Dat_i};
        descr = '0;
        pop   = '0;
        for (int j = 0; j < DW; j++) begin
            descr[j] = strm[j];
            for (int k = 1; k <= PP; k++) begin
                if (POLY[k]) descr[j] = descr[j] ^ strm[j + k];
            end
            pop = pop + PCW'(descr[j]);
        end
        sum = SW'(Err_Cnt) + SW'(pop);
    end

    always_ff @(posedge Ck or negedge Rs_n) begin
        if (!Rs_n) begin
            hist  <= DI;
            Vld_o <= 1'b0;
            Dat_o <= '0;
        end else if (CE) begin
            Vld_o <= Vld_i;
            if (Vld_i) begin
                hist  <= strm[PP-1:0];
                Dat_o <= descr;
            end
        end
    end

    // Mode 0 pins the FSM in HUNT, so any mode change restarts the hunt.
    always_ff @(posedge Ck or negedge Rs_n) begin
        if (!Rs_n) begin
            state <= HUNT;
            rc    <= '0;
        end else if (CE) begin
            if (!Mode) begin
                state <= HUNT;
                rc    <= '0;
            end else if (Vld_i) begin
                if (state == HUNT) begin
                    if (!clean) begin
                        rc <= '0;
                    end else if (rc_inc == RCW'(LOCK_N)) begin
                        state <= LOCKED;
                        rc    <= '0;
                    end else begin
                        rc <= rc_inc;
                    end
                end else begin
                    if (clean) begin
                        rc <= '0;
                    end else if (rc_inc == RCW'(UNLOCK_N)) begin
                        state <= HUNT;
                        rc    <= '0;
                    end else begin
                        rc <= rc_inc;
                    end
                end
            end
        end
    end

    always_ff @(posedge Ck or negedge Rs_n) begin
        if (!Rs_n) begin
            Err_Cnt <= '0;
        end else if (CE) begin
            if (Clr_Err) begin
                Err_Cnt <= '0;
            end else if (accept && Mode && state == LOCKED) begin
                Err_Cnt <= (sum > SAT) ? SAT[ECW-1:0] : sum[ECW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_descram_chk.sv
// tb/tb_descram_chk.sv - directed self-checking bench for descram_chk,
// default instance plus an ECW=4 instance sharing the same stimulus.
module tb_descram_chk;

    logic        Ck = 1'b0;
    logic        Rs_n, CE, Mode, Vld_i, Clr_Err;
    logic [31:0] Dat_i;
    logic        Vld_o, Lock;
    logic [31:0] Dat_o;
    logic [15:0] Err_Cnt;
    logic        s_vld, s_lock;
    logic [31:0] s_dat;
    logic [3:0]  s_err;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          main_err;
    logic [6:0]  tx_hist;

    always #5 Ck = ~Ck;

    descram_chk u_dut (
        .Ck(Ck), .Rs_n(Rs_n), .CE(CE), .Mode(Mode), .Vld_i(Vld_i), .Dat_i(Dat_i),
        .Clr_Err(Clr_Err), .Vld_o(Vld_o), .Dat_o(Dat_o), .Lock(Lock), .Err_Cnt(Err_Cnt)
    );

    descram_chk #(.ECW(4)) u_small (
        .Ck(Ck), .Rs_n(Rs_n), .CE(CE), .Mode(Mode), .Vld_i(Vld_i), .Dat_i(Dat_i),
        .Clr_Err(Clr_Err), .Vld_o(s_vld), .Dat_o(s_dat), .Lock(s_lock), .Err_Cnt(s_err)
    );

    // Bit-serial x^7+x^6+1 models, oldest bit (MSB) first; sr[0] is the newest.
    function automatic logic [31:0] scramble(input logic [6:0] h, input logic [31:0] d);
        logic [6:0]  sr;
        logic [31:0] c;
        sr = h;
        c  = '0;
        for (int i = 31; i >= 0; i--) begin
            c[i] = d[i] ^ sr[5] ^ sr[6];
            sr   = {sr[5:0], c[i]};
        end
        return c;
    endfunction

    function automatic logic [31:0] descramble(input logic [6:0] h, input logic [31:0] w);
        logic [6:0]  sr;
        logic [31:0] o;
        sr = h;
        o  = '0;
        for (int i = 31; i >= 0; i--) begin
            o[i] = w[i] ^ sr[5] ^ sr[6];
            sr   = {sr[5:0], w[i]};
        end
        return o;
    endfunction

    task automatic tick();
        @(posedge Ck);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        Dat_i   = w;
        Vld_i   = 1'b1;
        tx_hist = w[6:0];
        tick();
        Vld_i   = 1'b0;
    endtask

    task automatic do_reset();
        Rs_n = 1'b0;
        tick();
        Rs_n    = 1'b1;
        tx_hist = 7'h7F;
    endtask

    task automatic test_reset();
        CE = 1'b1; Mode = 1'b0; Clr_Err = 1'b0; Rs_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            Dat_i = $urandom;
            Vld_i = 1'($urandom_range(0, 1));
            tick();
            n_chk++;
            if (Vld_o !== 1'b0 || Dat_o !== 32'h0 || Lock !== 1'b0 || Err_Cnt !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: vld=%b dat=%h lock=%b err=%0d expected all 0",
                         i, Vld_o, Dat_o, Lock, Err_Cnt);
            end
        end
        Rs_n = 1'b1; Vld_i = 1'b0; tx_hist = 7'h7F;
        for (int i = 0; i < 2; i++) begin
            Dat_i = $urandom;
            tick();
            n_chk++;
            if (Vld_o !== 1'b0 || Dat_o !== 32'h0 || Lock !== 1'b0 || Err_Cnt !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_release cyc %0d: vld=%b dat=%h lock=%b err=%0d expected all 0",
                         i, Vld_o, Dat_o, Lock, Err_Cnt);
            end
        end
    endtask

    task automatic test_mode0();
        Mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(scramble(tx_hist, 32'hDEADBEEF));
            n_chk++;
            if (Vld_o !== 1'b1 || Dat_o !== 32'hDEADBEEF || Lock !== 1'b0) begin
                n_fail++;
                $display("FAIL mode0_word %0d: vld=%b dat=%h lock=%b expected 1 deadbeef 0",
                         i, Vld_o, Dat_o, Lock);
            end
            Dat_i = $urandom;
            tick();
            n_chk++;
            if (Vld_o !== 1'b0 || Dat_o !== 32'hDEADBEEF) begin
                n_fail++;
                $display("FAIL mode0_gap %0d: vld=%b dat=%h expected 0 deadbeef", i, Vld_o, Dat_o);
            end
        end
    endtask

    task automatic test_prbs_lock();
        Mode = 1'b1;
        do_reset();
        for (int n = 1; n <= 100; n++) begin
            send(scramble(tx_hist, 32'h0));
            n_chk++;
            if (Dat_o !== 32'h0 || Lock !== (n >= 4) || Err_Cnt !== 16'h0) begin
                n_fail++;
                $display("FAIL prbs_lock word %0d: dat=%h lock=%b err=%0d expected 0 %b 0",
                         n, Dat_o, Lock, Err_Cnt, (n >= 4));
            end
        end
    endtask

    task automatic test_single_err();
        send(scramble(tx_hist, 32'h0) ^ 32'h0000_8000);
        n_chk++;
        if (Dat_o !== 32'h0000_8300 || Err_Cnt !== 16'd3 || Lock !== 1'b1) begin
            n_fail++;
            $display("FAIL single_err: dat=%h err=%0d lock=%b expected 00008300 3 1",
                     Dat_o, Err_Cnt, Lock);
        end
        send(scramble(tx_hist, 32'h0));
        n_chk++;
        if (Dat_o !== 32'h0 || Err_Cnt !== 16'd3 || Lock !== 1'b1) begin
            n_fail++;
            $display("FAIL single_err_after: dat=%h err=%0d lock=%b expected 0 3 1",
                     Dat_o, Err_Cnt, Lock);
        end
    endtask

    task automatic test_ce_hold();
        CE = 1'b0; Vld_i = 1'b1; Dat_i = 32'hFFFF_FFFF; Clr_Err = 1'b1;
        tick();
        tick();
        n_chk++;
        if (Vld_o !== 1'b1 || Dat_o !== 32'h0 || Lock !== 1'b1 || Err_Cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL ce_hold: vld=%b dat=%h lock=%b err=%0d expected 1 0 1 3",
                     Vld_o, Dat_o, Lock, Err_Cnt);
        end
        CE = 1'b1; Vld_i = 1'b0; Clr_Err = 1'b0;
    endtask

    task automatic test_unlock();
        logic [31:0] exp;
        main_err = 3;
        for (int n = 1; n <= 5; n++) begin
            exp = descramble(tx_hist, 32'hFFFF_FFFF);
            if (n <= 4) main_err += $countones(exp);
            send(32'hFFFF_FFFF);
            n_chk++;
            if (Dat_o !== exp || Lock !== (n < 4) || Err_Cnt !== 16'(main_err)) begin
                n_fail++;
                $display("FAIL unlock word %0d: dat=%h lock=%b err=%0d expected %h %b %0d",
                         n, Dat_o, Lock, Err_Cnt, exp, (n < 4), main_err);
            end
        end
        for (int n = 1; n <= 4; n++) begin
            send(scramble(tx_hist, 32'h0));
            n_chk++;
            if (Dat_o !== 32'h0 || Lock !== (n == 4) || Err_Cnt !== 16'(main_err)) begin
                n_fail++;
                $display("FAIL relock word %0d: dat=%h lock=%b err=%0d expected 0 %b %0d",
                         n, Dat_o, Lock, Err_Cnt, (n == 4), main_err);
            end
        end
    endtask

    task automatic test_mode_switch();
        Mode = 1'b0;
        tick();
        n_chk++;
        if (Lock !== 1'b0 || Err_Cnt !== 16'(main_err)) begin
            n_fail++;
            $display("FAIL mode_switch_drop: lock=%b err=%0d expected 0 %0d", Lock, Err_Cnt, main_err);
        end
        Mode = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            send(scramble(tx_hist, 32'h0));
            n_chk++;
            if (Dat_o !== 32'h0 || Lock !== (n == 4)) begin
                n_fail++;
                $display("FAIL mode_switch_relock %0d: dat=%h lock=%b expected 0 %b",
                         n, Dat_o, Lock, (n == 4));
            end
        end
    endtask

    task automatic test_saturation();
        int p1;
        Clr_Err = 1'b1;
        tick();
        Clr_Err = 1'b0;
        n_chk++;
        if (Err_Cnt !== 16'h0 || s_err !== 4'h0) begin
            n_fail++;
            $display("FAIL clear: err=%0d small=%0d expected 0 0", Err_Cnt, s_err);
        end
        p1 = $countones(descramble(tx_hist, 32'hFFFF_FFFF));
        send(32'hFFFF_FFFF);
        n_chk++;
        if (Err_Cnt !== 16'(p1) || s_err !== 4'((p1 > 15) ? 15 : p1)) begin
            n_fail++;
            $display("FAIL sat_first: err=%0d small=%0d expected %0d %0d",
                     Err_Cnt, s_err, p1, (p1 > 15) ? 15 : p1);
        end
        send(32'hFFFF_FFFF);
        n_chk++;
        if (Err_Cnt !== 16'(p1 + 32) || s_err !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_hold: err=%0d small=%0d expected %0d 15", Err_Cnt, s_err, p1 + 32);
        end
        Clr_Err = 1'b1;
        send(32'hFFFF_FFFF);
        Clr_Err = 1'b0;
        n_chk++;
        if (Err_Cnt !== 16'h0 || s_err !== 4'h0 || Lock !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_wins: err=%0d small=%0d lock=%b expected 0 0 1", Err_Cnt, s_err, Lock);
        end
        send(32'hFFFF_FFFF);
        n_chk++;
        if (Err_Cnt !== 16'd32 || s_err !== 4'd15 || Lock !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_unlock: err=%0d small=%0d lock=%b expected 32 15 0", Err_Cnt, s_err, Lock);
        end
    endtask

    task automatic test_reset_mid();
        for (int n = 1; n <= 4; n++) send(scramble(tx_hist, 32'h0));
        n_chk++;
        if (Lock !== 1'b1 || Vld_o !== 1'b1 || Err_Cnt !== 16'd32) begin
            n_fail++;
            $display("FAIL pre_reset: lock=%b vld=%b err=%0d expected 1 1 32", Lock, Vld_o, Err_Cnt);
        end
        Vld_i = 1'b1; Dat_i = 32'hFFFF_FFFF;
        Rs_n  = 1'b0;
        #1;
        n_chk++;
        if (Vld_o !== 1'b0 || Dat_o !== 32'h0 || Lock !== 1'b0 || Err_Cnt !== 16'h0 || s_err !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_async: vld=%b dat=%h lock=%b err=%0d small=%0d expected all 0",
                     Vld_o, Dat_o, Lock, Err_Cnt, s_err);
        end
        tick();
        Rs_n = 1'b1; Vld_i = 1'b0; tx_hist = 7'h7F;
        send(scramble(tx_hist, 32'h0));
        n_chk++;
        if (Vld_o !== 1'b1 || Dat_o !== 32'h0 || Lock !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_history: vld=%b dat=%h lock=%b expected 1 0 0", Vld_o, Dat_o, Lock);
        end
    endtask

    initial begin
        Rs_n = 1'b0; CE = 1'b1; Mode = 1'b0; Vld_i = 1'b0; Clr_Err = 1'b0;
        Dat_i = '0; tx_hist = 7'h7F; main_err = 0;
        test_reset();
        test_mode0();
        test_prbs_lock();
        test_single_err();
        test_ce_hold();
        test_unlock();
        test_mode_switch();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
